exc_ctrl: RTL

//  Commit-stage exception initiator driving the CP0 trap/return interface of the single-issue MIPS core.

---
 rtl/exc_ctrl_pkg.sv | 29 ++
 rtl/exc_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the commit-stage exception controller: cause codes,
// CP0 status bit positions, FSM encoding and common constants.
package exc_ctrl_pkg;

    localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
    localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

    localparam int ST_GLOBAL  = 0;
    localparam int ST_SYSCALL = 1;
    localparam int ST_BREAK   = 2;
    localparam int ST_TEQ     = 3;

    localparam logic        ENABLE    = 1'b1;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTER    = 2'd1,
        REDIRECT = 2'd2,
        RETURN   = 2'd3
    } exc_state_e;

    typedef struct packed {
        logic       taken;
        logic [4:0] cause;
    } trap_t;

endpackage

// File: rtl/exc_ctrl.sv
// Commit-stage exception initiator: trap detection, CP0 strobes, stall/flush and PC redirect.
// Optional taken-exception counter is built when EXC_CTRL_STATS_EN is defined.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [31:0]      inst_pc,
    input  logic             is_syscall,
    input  logic             is_break,
    input  logic             is_teq,
    input  logic             teq_equal,
    input  logic             is_eret,
    input  logic [31:0]      status,
    input  logic [31:0]      epc,
    output logic             cp0_exception,
    output logic             cp0_eret,
    output logic [4:0]       cp0_cause,
    output logic [31:0]      cp0_pc,
    output logic             stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] exc_count,
    output exc_state_e       dbg_state
);

    exc_state_e  state_q, state_d;
    logic [4:0]  cause_q;
    logic [31:0] pc_q;
    trap_t       trap;

    // Priority syscall > break > teq; each source needs global enable plus its own mask bit.
    function automatic trap_t detect_trap(
        input logic        valid,
        input logic        sys,
        input logic        brk,
        input logic        teq,
        input logic        teq_eq,
        input logic [31:0] st
    );
        trap_t t;
        t.taken = 1'b0;
        t.cause = 5'b0;
        if (valid && st[ST_GLOBAL]) begin
            if (sys && st[ST_SYSCALL]) begin
                t.taken = ENABLE;
                t.cause = CAUSE_SYSCALL;
            end else if (brk && st[ST_BREAK]) begin
                t.taken = ENABLE;
                t.cause = CAUSE_BREAK;
            end else if (teq && teq_eq && st[ST_TEQ]) begin
                t.taken = ENABLE;
                t.cause = CAUSE_TEQ;
            end
        end
        return t;
    endfunction

    assign trap = detect_trap(inst_valid, is_syscall, is_break, is_teq, teq_equal, status);

    logic unused_status;
    assign unused_status = ^status[31:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cause_q <= 5'b0;
            pc_q    <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && trap.taken) begin
                cause_q <= trap.cause;
                pc_q    <= inst_pc;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cp0_exception  = 1'b0;
        cp0_eret       = 1'b0;
        cp0_cause      = 5'b0;
        cp0_pc         = ZERO_WORD;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = ZERO_WORD;
        case (state_q)
            IDLE: begin
                // A taken trap wins over an eret arriving in the same cycle.
                if (trap.taken) begin
                    state_d = ENTER;
                end else if (inst_valid && is_eret) begin
                    state_d = RETURN;
                end
            end
            ENTER: begin
                cp0_exception = 1'b1;
                cp0_cause     = cause_q;
                cp0_pc        = pc_q;
                stall         = 1'b1;
                flush         = 1'b1;
                state_d       = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = EXC_VECTOR;
                stall          = 1'b1;
                state_d        = IDLE;
            end
            RETURN: begin
                cp0_eret       = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = epc;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

`ifdef EXC_CTRL_STATS_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (state_q == ENTER && count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign exc_count = count_q;
`else
    assign exc_count = '0;
`endif

endmodule
